controle_cancela: RTL and testbench

CONTROLE_CANCELA -- requirements
Module: controle_cancela

---
 rtl/controle_cancela_pkg.sv | 28 ++
 rtl/controle_cancela_borda.sv | 22 ++
 rtl/controle_cancela.sv | 148 ++++++++++++++
 tb/tb_controle_cancela.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_cancela_pkg.sv
// Shared definitions for the entry barrier controller: state encoding,
// default timing values and the lot capacity shared with the counter stage.
package controle_cancela_pkg;

   typedef enum logic [1:0] {
      FECHADA  = 2'd0,
      ABRINDO  = 2'd1,
      ABERTA   = 2'd2,
      FECHANDO = 2'd3
   } estado_t;

   // Occupancy width of the counter stage; capacity must fit in it.
   localparam int unsigned OCUP_W            = 6;
   localparam int unsigned CAPACIDADE_PADRAO = 63;

   // Default phase durations in clock cycles (each 1..255).
   localparam int unsigned T_ABRIR_PADRAO    = 4;
   localparam int unsigned T_FECHAR_PADRAO   = 4;
   localparam int unsigned T_TIMEOUT_PADRAO  = 32;

   localparam int unsigned TIMER_W           = 8;

   // Timer load value for a phase lasting t cycles (timer counts t-1 down to 0).
   function automatic logic [TIMER_W-1:0] carga(input int unsigned t);
      return TIMER_W'(t - 1);
   endfunction

endpackage

// File: rtl/controle_cancela_borda.sv
// Registered edge detector: keeps the previous sample of a synchronous
// level and flags rising and falling transitions against it.
module detector_borda (
   input  logic clk,
   input  logic reset,
   input  logic sinal_i,
   output logic subida_o,
   output logic descida_o
);

   logic anterior_q;

   // Previous-sample register, cleared by the active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) anterior_q <= 1'b0;
      else        anterior_q <= sinal_i;
   end

   assign subida_o  = sinal_i & ~anterior_q;
   assign descida_o = ~sinal_i & anterior_q;

endmodule

// File: rtl/controle_cancela.sv
// Entry barrier controller: opens on an accepted ticket request, waits for
// the car to cross the beam (or a timeout), then closes. Emits one entry
// pulse per car for the car-monitor stage and refuses entry when the lot is
// full or a flood condition is flagged.
import controle_cancela_pkg::*;

module controle_cancela #(
   parameter int unsigned CAPACIDADE = CAPACIDADE_PADRAO,
   parameter int unsigned T_ABRIR    = T_ABRIR_PADRAO,
   parameter int unsigned T_FECHAR   = T_FECHAR_PADRAO,
   parameter int unsigned T_TIMEOUT  = T_TIMEOUT_PADRAO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pedido,
   input  logic              passagem,
   input  logic [OCUP_W-1:0] occupancy,
   input  logic              alerta,
   input  logic              emergencia,
   output logic              motor_abrir,
   output logic              motor_fechar,
   output logic              cancela_aberta,
   output logic              sensor_ent,
   output logic              negado,
   output logic              lotado
);

   estado_t              estado_q, estado_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 carro_visto_q, carro_visto_d;
   // Set once the entry pulse was issued, so a safety reopen cannot count the same car twice.
   logic                 contado_q, contado_d;
   logic                 sensor_ent_q, sensor_ent_d;
   logic                 negado_q, negado_d;

   logic                 pedido_sobe, pedido_desce;
   logic                 passagem_sobe, passagem_desce;
   logic                 bordas_unused;

   detector_borda u_borda_pedido (
      .clk       (clk),
      .reset     (reset),
      .sinal_i   (pedido),
      .subida_o  (pedido_sobe),
      .descida_o (pedido_desce)
   );

   detector_borda u_borda_passagem (
      .clk       (clk),
      .reset     (reset),
      .sinal_i   (passagem),
      .subida_o  (passagem_sobe),
      .descida_o (passagem_desce)
   );

   assign bordas_unused = pedido_desce ^ passagem_sobe;

   assign lotado = ({{(32-OCUP_W){1'b0}}, occupancy} >= CAPACIDADE);

   // Next-state, timer and pulse decisions; any reload overrides the default decrement.
   always_comb begin
      estado_d      = estado_q;
      timer_d       = timer_q;
      carro_visto_d = carro_visto_q;
      contado_d     = contado_q;
      sensor_ent_d  = 1'b0;
      negado_d      = 1'b0;
      if (timer_q != '0) timer_d = timer_q - 1'b1;

      case (estado_q)
         FECHADA: begin
            if (pedido_sobe) begin
               if (lotado || alerta || emergencia) begin
                  negado_d = 1'b1;
               end else begin
                  estado_d = ABRINDO;
                  timer_d  = carga(T_ABRIR);
               end
            end
         end
         ABRINDO: begin
            if (emergencia) begin
               estado_d = FECHANDO;
               timer_d  = carga(T_FECHAR);
            end else if (timer_q == '0) begin
               estado_d = ABERTA;
               timer_d  = carga(T_TIMEOUT);
            end
         end
         ABERTA: begin
            if (passagem) begin
               // Vehicle under the barrier: remember it and freeze the timeout.
               carro_visto_d = 1'b1;
               timer_d       = timer_q;
            end else if (passagem_desce && carro_visto_q) begin
               sensor_ent_d = ~contado_q;
               contado_d    = 1'b1;
               estado_d     = FECHANDO;
               timer_d      = carga(T_FECHAR);
            end else if (emergencia || timer_q == '0) begin
               estado_d = FECHANDO;
               timer_d  = carga(T_FECHAR);
            end
         end
         FECHANDO: begin
            if (passagem) begin
               // Safety reopen; carro_visto is kept so the car is counted when it clears.
               estado_d = ABERTA;
               timer_d  = carga(T_TIMEOUT);
            end else if (timer_q == '0) begin
               estado_d      = FECHADA;
               carro_visto_d = 1'b0;
               contado_d     = 1'b0;
            end
         end
         default: begin
            estado_d = FECHADA;
            timer_d  = '0;
         end
      endcase
   end

   // State, timer, flags and registered pulses, with active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q      <= FECHADA;
         timer_q       <= '0;
         carro_visto_q <= 1'b0;
         contado_q     <= 1'b0;
         sensor_ent_q  <= 1'b0;
         negado_q      <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         timer_q       <= timer_d;
         carro_visto_q <= carro_visto_d;
         contado_q     <= contado_d;
         sensor_ent_q  <= sensor_ent_d;
         negado_q      <= negado_d;
      end
   end

   assign motor_abrir    = (estado_q == ABRINDO);
   assign motor_fechar   = (estado_q == FECHANDO);
   assign cancela_aberta = (estado_q == ABERTA);
   assign sensor_ent     = sensor_ent_q;
   assign negado         = negado_q;

endmodule

// File: tb/tb_controle_cancela.sv
// Self-checking bench for controle_cancela: directed scenarios with
// expectations taken from the barrier rules, then randomized stimulus
// compared each cycle against a phase/remaining-cycles reference model.
module tb_controle_cancela;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pedido = 1'b0;
   logic       passagem = 1'b0;
   logic       alerta = 1'b0;
   logic       emergencia = 1'b0;
   logic [5:0] occupancy = 6'd0;
   logic       motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado, lotado;

   int checks = 0;
   int erros  = 0;
   int pulsos = 0;

   controle_cancela dut (
      .clk            (clk),
      .reset          (reset),
      .pedido         (pedido),
      .passagem       (passagem),
      .occupancy      (occupancy),
      .alerta         (alerta),
      .emergencia     (emergencia),
      .motor_abrir    (motor_abrir),
      .motor_fechar   (motor_fechar),
      .cancela_aberta (cancela_aberta),
      .sensor_ent     (sensor_ent),
      .negado         (negado),
      .lotado         (lotado)
   );

   always #5 clk = ~clk;

   // Reference model: phase plus cycles remaining in it.
   localparam int M_FECHADA = 0, M_ABRINDO = 1, M_ABERTA = 2, M_FECHANDO = 3;
   int m_fase = M_FECHADA;
   int m_rest = 0;
   bit m_visto = 0, m_contado = 0, m_ped_ant = 0, m_pas_ant = 0;
   bit m_sensor = 0, m_negado = 0;

   always @(posedge clk) begin
      bit sobe, desce;
      if (!reset) begin
         m_fase = M_FECHADA; m_rest = 0; m_visto = 0; m_contado = 0;
         m_ped_ant = 0; m_pas_ant = 0; m_sensor = 0; m_negado = 0;
      end else begin
         sobe  = pedido && !m_ped_ant;
         desce = !passagem && m_pas_ant;
         m_sensor = 0;
         m_negado = 0;
         case (m_fase)
            M_FECHADA:
               if (sobe) begin
                  if (occupancy >= 63 || alerta || emergencia) m_negado = 1;
                  else begin m_fase = M_ABRINDO; m_rest = 4; end
               end
            M_ABRINDO:
               if (emergencia) begin m_fase = M_FECHANDO; m_rest = 4; end
               else if (m_rest <= 1) begin m_fase = M_ABERTA; m_rest = 32; end
               else m_rest--;
            M_ABERTA:
               if (passagem) m_visto = 1;
               else if (desce && m_visto) begin
                  m_sensor = !m_contado; m_contado = 1;
                  m_fase = M_FECHANDO; m_rest = 4;
               end else if (emergencia || m_rest <= 1) begin m_fase = M_FECHANDO; m_rest = 4; end
               else m_rest--;
            default:
               if (passagem) begin m_fase = M_ABERTA; m_rest = 32; end
               else if (m_rest <= 1) begin m_fase = M_FECHADA; m_visto = 0; m_contado = 0; end
               else m_rest--;
         endcase
         m_ped_ant = pedido;
         m_pas_ant = passagem;
      end
   end

   // Advance to the next sampling point and tally entry pulses seen.
   task automatic passo();
      @(negedge clk);
      if (sensor_ent === 1'b1) pulsos++;
   endtask

   task automatic abrir();
      int k;
      pedido = 1'b1;
      passo();
      pedido = 1'b0;
      k = 0;
      while (cancela_aberta !== 1'b1 && k < 20) begin passo(); k++; end
   endtask

   task automatic espera_fechada();
      int k;
      k = 0;
      while ((motor_abrir | motor_fechar | cancela_aberta) !== 1'b0 && k < 80) begin passo(); k++; end
   endtask

   task automatic test_reset();
      reset = 1'b0; occupancy = 6'd63; pedido = 1'b1; passagem = 1'b1;
      passo(); passo();
      checks++;
      if ({motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado} !== 5'b0) begin
         erros++; $display("FAIL reset_saidas: got %b expected 00000",
                           {motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado});
      end
      checks++;
      if (lotado !== 1'b1) begin erros++; $display("FAIL reset_lotado63: got %b expected 1", lotado); end
      occupancy = 6'd10; #1;
      checks++;
      if (lotado !== 1'b0) begin erros++; $display("FAIL reset_lotado10: got %b expected 0", lotado); end
      reset = 1'b1; pedido = 1'b0; passagem = 1'b0;
      passo();
   endtask

   task automatic test_entrada_normal();
      int n, nf;
      occupancy = 6'd10;
      pedido = 1'b1; passo(); pedido = 1'b0;
      n = 0;
      while (motor_abrir === 1'b1 && n < 20) begin n++; passo(); end
      checks++;
      if (n != 4) begin erros++; $display("FAIL normal_abrindo: got %0d cycles expected 4", n); end
      checks++;
      if (cancela_aberta !== 1'b1) begin erros++; $display("FAIL normal_aberta: got %b expected 1", cancela_aberta); end
      pulsos = 0;
      passagem = 1'b1; repeat (3) passo();
      passagem = 1'b0;
      nf = 0;
      for (int k = 0; k < 30; k++) begin
         passo();
         if (motor_fechar === 1'b1) nf++;
         if ((motor_abrir | motor_fechar | cancela_aberta) === 1'b0) break;
      end
      checks++;
      if (pulsos != 1) begin erros++; $display("FAIL normal_sensor: got %0d pulses expected 1", pulsos); end
      checks++;
      if (nf != 4) begin erros++; $display("FAIL normal_fechando: got %0d cycles expected 4", nf); end
   endtask

   task automatic test_lotado();
      for (int r = 0; r < 2; r++) begin
         occupancy = (r == 0) ? 6'd63 : 6'd5;
         alerta    = (r == 1);
         pedido = 1'b1; passo();
         checks++;
         if (negado !== 1'b1) begin erros++; $display("FAIL lotado_negado r%0d: got %b expected 1", r, negado); end
         checks++;
         if (motor_abrir !== 1'b0) begin erros++; $display("FAIL lotado_motor r%0d: got %b expected 0", r, motor_abrir); end
         passo(); passo();
         checks++;
         if ({negado, motor_abrir} !== 2'b00) begin
            erros++; $display("FAIL lotado_pulso r%0d: got %b expected 00", r, {negado, motor_abrir});
         end
         pedido = 1'b0; passo();
      end
      alerta = 1'b0; occupancy = 6'd10;
   endtask

   task automatic test_timeout();
      int n;
      abrir();
      pulsos = 0;
      n = 0;
      while (cancela_aberta === 1'b1 && n < 100) begin n++; passo(); end
      checks++;
      if (n != 32) begin erros++; $display("FAIL timeout_ciclos: got %0d expected 32", n); end
      checks++;
      if (motor_fechar !== 1'b1) begin erros++; $display("FAIL timeout_fechando: got %b expected 1", motor_fechar); end
      espera_fechada();
      checks++;
      if (pulsos != 0) begin erros++; $display("FAIL timeout_sensor: got %0d pulses expected 0", pulsos); end
   endtask

   task automatic test_reabertura();
      abrir();
      pulsos = 0;
      passagem = 1'b1; passo(); passo();
      passagem = 1'b0; passo();
      checks++;
      if ({motor_fechar, sensor_ent} !== 2'b11) begin
         erros++; $display("FAIL reabre_primeiro: got %b expected 11", {motor_fechar, sensor_ent});
      end
      passagem = 1'b1; passo();
      checks++;
      if (cancela_aberta !== 1'b1) begin erros++; $display("FAIL reabre_aberta: got %b expected 1", cancela_aberta); end
      passo();
      passagem = 1'b0; passo();
      checks++;
      if (motor_fechar !== 1'b1) begin erros++; $display("FAIL reabre_fecha: got %b expected 1", motor_fechar); end
      espera_fechada();
      checks++;
      if (pulsos != 1) begin erros++; $display("FAIL reabre_total: got %0d pulses expected 1", pulsos); end
   endtask

   task automatic test_emergencia();
      occupancy = 6'd62;
      pedido = 1'b1; passo(); pedido = 1'b0;
      checks++;
      if ({lotado, motor_abrir} !== 2'b01) begin
         erros++; $display("FAIL emerg_62aceito: got %b expected 01", {lotado, motor_abrir});
      end
      emergencia = 1'b1; passo();
      checks++;
      if (motor_fechar !== 1'b1) begin erros++; $display("FAIL emerg_abrindo: got %b expected 1", motor_fechar); end
      emergencia = 1'b0;
      espera_fechada();
      occupancy = 6'd10;
      abrir();
      pulsos = 0;
      passagem = 1'b1; passo(); emergencia = 1'b1;
      repeat (3) passo();
      checks++;
      if (cancela_aberta !== 1'b1) begin erros++; $display("FAIL emerg_passagem: got %b expected 1", cancela_aberta); end
      passagem = 1'b0; passo();
      checks++;
      if ({motor_fechar, pulsos[0]} !== 2'b11) begin
         erros++; $display("FAIL emerg_libera: got fechar=%b pulsos=%0d expected 1 and 1", motor_fechar, pulsos);
      end
      emergencia = 1'b0;
      espera_fechada();
   endtask

   task automatic test_reset_passagem();
      abrir();
      pulsos = 0;
      passagem = 1'b1; passo();
      checks++;
      if (cancela_aberta !== 1'b1) begin erros++; $display("FAIL rstpass_aberta: got %b expected 1", cancela_aberta); end
      reset = 1'b0; passo();
      checks++;
      if ({motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado} !== 5'b0) begin
         erros++; $display("FAIL rstpass_saidas: got %b expected 00000",
                           {motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado});
      end
      passagem = 1'b0; passo();
      reset = 1'b1; passo(); passo();
      checks++;
      if (pulsos != 0 || {motor_abrir, motor_fechar, cancela_aberta} !== 3'b0) begin
         erros++; $display("FAIL rstpass_depois: got pulsos=%0d motores=%b expected 0 and 000",
                           pulsos, {motor_abrir, motor_fechar, cancela_aberta});
      end
   endtask

   task automatic test_aleatorio();
      logic [5:0] obs, esp;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         obs = {motor_abrir, motor_fechar, cancela_aberta, sensor_ent, negado, lotado};
         esp = {m_fase == M_ABRINDO, m_fase == M_FECHANDO, m_fase == M_ABERTA,
                m_sensor, m_negado, occupancy >= 6'd63};
         checks++;
         if (obs !== esp) begin
            erros++; $display("FAIL aleatorio ciclo %0d: got %b expected %b", c, obs, esp);
         end
         reset      = ($urandom_range(0, 199) != 0);
         pedido     = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 5) == 0) passagem = ~passagem;
         occupancy  = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
         alerta     = ($urandom_range(0, 19) == 0);
         emergencia = ($urandom_range(0, 29) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_entrada_normal();
      test_lotado();
      test_timeout();
      test_reabertura();
      test_emergencia();
      test_reset_passagem();
      test_aleatorio();
      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end

endmodule
